// File: rtl/ebpf_alu64_addsub_seq.sv
// ebpf_alu64_addsub_seq
//   Multi-cycle 64-bit add/subtract/compare sequencer for the eBPF core. Each operation runs
//   through one 32-bit adder: a low-word pass, then (for 64-bit ops) a high-word pass that uses
//   the low-word carry. The sequencer produces {N,Z,C,V} flags and the conditional-jump predicate.
//
// Ports
//   clk, rst_n          core clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake; in_ready is high only in IDLE
//   op                  00 ADD, 01 SUB, 10 CMP, 11 reserved (runs as ADD, taken=0)
//   alu32               1 = 32-bit op (single pass)
//   cond                jump condition, only used for CMP
//   a, b                64-bit operands (dst, src/imm)
//   out_valid/out_ready downstream handshake
//   result, flags, taken  sum/difference, {N,Z,C,V}, jump predicate
module ebpf_alu64_addsub_seq #(
    parameter bit ZEXT32 = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic        alu32,
    input  logic [3:0]  cond,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic [3:0]  flags,
    output logic        taken
);

    typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

    state_e      state_q, state_d;
    logic [63:0] a_q, a_d, b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic        alu32_q, alu32_d;
    logic [3:0]  cond_q, cond_d;
    logic [31:0] lo_q, lo_d;
    logic        c32_q, c32_d;
    logic        out_valid_q, out_valid_d;
    logic [63:0] result_q, result_d;
    logic [3:0]  flags_q, flags_d;
    logic        taken_q, taken_d;

    // Shared 32-bit datapath
    logic        sub, in_hi;
    logic [31:0] add_x, b_word, add_y;
    logic        add_cin;
    logic [32:0] add_sum;
    logic        fin_n, fin_z, fin_c, fin_v, jset, pred;
    logic [63:0] fin_res;

    always_comb begin
        sub     = (op_q == 2'b01) || (op_q == 2'b10);
        in_hi   = (state_q == StHi);
        add_x   = in_hi ? a_q[63:32] : a_q[31:0];
        b_word  = in_hi ? b_q[63:32] : b_q[31:0];
        add_y   = sub ? ~b_word : b_word;
        // Low pass: carry-in is the +1 of two's-complement subtract; high pass: low-word carry.
        add_cin = in_hi ? c32_q : sub;
        add_sum = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};

        // Flags at the effective width; the top pass always sits in add_sum.
        fin_n = add_sum[31];
        fin_c = add_sum[32];
        fin_v = (add_x[31] == add_y[31]) && (add_sum[31] != add_x[31]);
        fin_z = (add_sum[31:0] == 32'd0) && (alu32_q || (lo_q == 32'd0));
        if (alu32_q) begin
            fin_res = {(ZEXT32 ? 32'd0 : {32{add_sum[31]}}), add_sum[31:0]};
            jset    = |(a_q[31:0] & b_q[31:0]);
        end else begin
            fin_res = {add_sum[31:0], lo_q};
            jset    = |(a_q & b_q);
        end

        case (cond_q)
            4'd0:    pred = fin_z;
            4'd1:    pred = !fin_z;
            4'd2:    pred = fin_c && !fin_z;
            4'd3:    pred = fin_c;
            4'd4:    pred = !fin_c;
            4'd5:    pred = !fin_c || fin_z;
            4'd6:    pred = !fin_z && (fin_n == fin_v);
            4'd7:    pred = (fin_n == fin_v);
            4'd8:    pred = (fin_n != fin_v);
            4'd9:    pred = fin_z || (fin_n != fin_v);
            4'd10:   pred = jset;
            default: pred = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        alu32_d     = alu32_q;
        cond_d      = cond_q;
        lo_d        = lo_q;
        c32_d       = c32_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        taken_d     = taken_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    alu32_d = alu32;
                    cond_d  = cond;
                    state_d = StLo;
                end
            end
            StLo: begin
                lo_d  = add_sum[31:0];
                c32_d = add_sum[32];
                if (alu32_q) begin
                    result_d    = fin_res;
                    flags_d     = {fin_n, fin_z, fin_c, fin_v};
                    taken_d     = (op_q == 2'b10) && pred;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    state_d = StHi;
                end
            end
            StHi: begin
                result_d    = fin_res;
                flags_d     = {fin_n, fin_z, fin_c, fin_v};
                taken_d     = (op_q == 2'b10) && pred;
                out_valid_d = 1'b1;
                state_d     = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            alu32_q     <= 1'b0;
            cond_q      <= '0;
            lo_q        <= '0;
            c32_q       <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            taken_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            alu32_q     <= alu32_d;
            cond_q      <= cond_d;
            lo_q        <= lo_d;
            c32_q       <= c32_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            taken_q     <= taken_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;
    assign taken     = taken_q;

endmodule

// File: tb/tb_ebpf_alu64_addsub_seq.sv
// Directed-vector bench for ebpf_alu64_addsub_seq. Two instances share the stimulus: one
// zero-extends alu32 results, the other sign-extends them.
module tb_ebpf_alu64_addsub_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  op;
    logic        alu32;
    logic [3:0]  cond;
    logic [63:0] a, b;
    logic        out_ready;
    logic        in_ready, out_valid, taken;
    logic [63:0] result;
    logic [3:0]  flags;
    logic        in_ready_s, out_valid_s, taken_s;
    logic [63:0] result_s;
    logic [3:0]  flags_s;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ebpf_alu64_addsub_seq #(.ZEXT32(1'b1)) dut_z (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .alu32(alu32), .cond(cond), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags), .taken(taken)
    );

    ebpf_alu64_addsub_seq #(.ZEXT32(1'b0)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .op(op),
        .alu32(alu32), .cond(cond), .a(a), .b(b), .out_valid(out_valid_s),
        .out_ready(out_ready), .result(result_s), .flags(flags_s), .taken(taken_s)
    );

    typedef struct {
        logic [1:0]  op;
        logic        w32;
        logic [3:0]  cond;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;   // expected with zero extension
        logic [3:0]  flg;   // {N,Z,C,V}
        logic        tk;
        int          hold;  // backpressure cycles in DONE
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic run_op(input int idx, input vec_t v);
        int          lat;
        logic [63:0] exp_s;
        exp_s = v.w32 ? {{32{v.res[31]}}, v.res[31:0]} : v.res;
        @(negedge clk);
        op = v.op; alu32 = v.w32; cond = v.cond; a = v.a; b = v.b;
        in_valid = 1'b1; out_ready = 1'b0;
        chk($sformatf("v%0d in_ready before accept", idx), 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        // Scramble inputs: only captured copies may matter from here on.
        in_valid = 1'b0; op = ~v.op; alu32 = ~v.w32; cond = ~v.cond; a = ~v.a; b = ~v.b;
        lat = 0;
        while (!out_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("v%0d latency", idx), 64'(lat), v.w32 ? 64'd1 : 64'd2);
        chk($sformatf("v%0d result", idx), result, v.res);
        chk($sformatf("v%0d flags", idx), 64'(flags), 64'(v.flg));
        chk($sformatf("v%0d taken", idx), 64'(taken), 64'(v.tk));
        chk($sformatf("v%0d sext result", idx), result_s, exp_s);
        chk($sformatf("v%0d sext flags", idx), 64'(flags_s), 64'(v.flg));
        chk($sformatf("v%0d in_ready in DONE", idx), 64'(in_ready), 64'd0);
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk); #1;
            chk($sformatf("v%0d hold%0d out_valid", idx, i), 64'(out_valid), 64'd1);
            chk($sformatf("v%0d hold%0d result", idx, i), result, v.res);
            chk($sformatf("v%0d hold%0d flags/taken", idx, i), 64'({flags, taken}),
                64'({v.flg, v.tk}));
            chk($sformatf("v%0d hold%0d in_ready", idx, i), 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk($sformatf("v%0d out_valid after handshake", idx), 64'(out_valid), 64'd0);
        chk($sformatf("v%0d in_ready after handshake", idx), 64'(in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        int   lat;
        //           op    w32   cond   a                       b                       res                     flg      tk    hold
        vecs[0]  = '{2'd0, 1'b0, 4'd0,  64'h0000_0000_FFFF_FFFF, 64'd1,                  64'h0000_0001_0000_0000, 4'b0000, 1'b0, 0};
        vecs[1]  = '{2'd2, 1'b0, 4'd2,  64'd5,                   64'hFFFF_FFFF_FFFF_FFFF, 64'd6,                  4'b0000, 1'b0, 0};
        vecs[2]  = '{2'd2, 1'b0, 4'd6,  64'd5,                   64'hFFFF_FFFF_FFFF_FFFF, 64'd6,                  4'b0000, 1'b1, 0};
        vecs[3]  = '{2'd1, 1'b0, 4'd0,  64'h8000_0000_0000_0000, 64'd1,                  64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 1'b0, 0};
        vecs[4]  = '{2'd0, 1'b1, 4'd0,  64'h1234_5678_FFFF_FFFF, 64'd1,                  64'd0,                   4'b0110, 1'b0, 0};
        vecs[5]  = '{2'd0, 1'b1, 4'd0,  64'h0000_0000_7FFF_FFFF, 64'd1,                  64'h0000_0000_8000_0000, 4'b1001, 1'b0, 0};
        vecs[6]  = '{2'd2, 1'b0, 4'd10, 64'hF0,                  64'h0F,                 64'hE1,                  4'b0010, 1'b0, 5};
        vecs[7]  = '{2'd2, 1'b0, 4'd10, 64'hF0,                  64'h10,                 64'hE0,                  4'b0010, 1'b1, 2};
        vecs[8]  = '{2'd2, 1'b0, 4'd0,  64'h1234_0000_0000_0000, 64'h1234_0000_0000_0000, 64'd0,                  4'b0110, 1'b1, 0};
        vecs[9]  = '{2'd2, 1'b0, 4'd4,  64'd1,                   64'd2,                  64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b1, 0};
        vecs[10] = '{2'd2, 1'b1, 4'd5,  64'hFFFF_FFFF_0000_0003, 64'd3,                  64'd0,                   4'b0110, 1'b1, 0};
        vecs[11] = '{2'd2, 1'b1, 4'd8,  64'h0000_0000_8000_0000, 64'd1,                  64'h0000_0000_7FFF_FFFF, 4'b0011, 1'b1, 0};
        vecs[12] = '{2'd3, 1'b0, 4'd1,  64'd2,                   64'd3,                  64'd5,                   4'b0000, 1'b0, 0};
        vecs[13] = '{2'd2, 1'b0, 4'd12, 64'd3,                   64'd1,                  64'd2,                   4'b0010, 1'b0, 0};
        vecs[14] = '{2'd2, 1'b0, 4'd7,  64'hFFFF_FFFF_FFFF_FFFE, 64'd1,                  64'hFFFF_FFFF_FFFF_FFFD, 4'b1010, 1'b0, 0};
        vecs[15] = '{2'd2, 1'b1, 4'd3,  64'h10,                  64'h20,                 64'h0000_0000_FFFF_FFF0, 4'b1000, 1'b0, 0};
        vecs[16] = '{2'd1, 1'b0, 4'd0,  64'h0000_0001_0000_0000, 64'd1,                  64'h0000_0000_FFFF_FFFF, 4'b0010, 1'b0, 0};
        vecs[17] = '{2'd2, 1'b0, 4'd9,  64'd5,                   64'd5,                  64'd0,                   4'b0110, 1'b1, 0};

        // Reset state, with a request presented that must be ignored.
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        op = 2'd0; alu32 = 1'b0; cond = 4'd0; a = 64'd7; b = 64'd9;
        #12;
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset result", result, 64'd0);
        chk("reset flags/taken", 64'({flags, taken}), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) run_op(i, vecs[i]);

        // Reset while in HI: op dropped, no clock edge needed.
        @(negedge clk);
        op = 2'd0; alu32 = 1'b0; cond = 4'd0; a = 64'hAAAA_AAAA_AAAA_AAAA; b = 64'h1111;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("hi-reset out_valid before", 64'(out_valid), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("hi-reset in_ready", 64'(in_ready), 64'd1);
        chk("hi-reset out_valid", 64'(out_valid), 64'd0);
        chk("hi-reset result cleared", result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("hi-reset no output %0d", i), 64'(out_valid), 64'd0);
        end
        rv = '{2'd0, 1'b0, 4'd0, 64'd2, 64'd3, 64'd5, 4'b0000, 1'b0, 0};
        run_op(100, rv);

        // Reset while in DONE: out_valid drops asynchronously.
        @(negedge clk);
        op = 2'd0; alu32 = 1'b1; cond = 4'd0; a = 64'd40; b = 64'd2;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("done-reset out_valid before", 64'(out_valid), 64'd1);
        chk("done-reset result before", result, 64'd42);
        rst_n = 1'b0;
        #1;
        chk("done-reset out_valid", 64'(out_valid), 64'd0);
        chk("done-reset in_ready", 64'(in_ready), 64'd1);
        chk("done-reset result", result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rv = '{2'd1, 1'b0, 4'd0, 64'd9, 64'd4, 64'd5, 4'b0010, 1'b0, 1};
        run_op(101, rv);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
